// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART transmit arbiter.
//   - FSM state encoding used by uart_tx_arbiter (IDLE / WAIT_BUSY / WAIT_DONE)
//   - UART_DW: byte width of the uart_tx data_in port
//   - ARB_ACCEPT_TIMEOUT: number of WAIT_BUSY cycles with tx_rdy still high
//     after which the launched byte is treated as already taken
package uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam int UART_DW            = 8;
    localparam int ARB_ACCEPT_TIMEOUT = 4;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   Scans valid[last+1], valid[last+2], ... modulo N (wrapping past N-1 to 0)
//   and reports the first set index. The last index itself has the lowest
//   priority, so a continuously valid set rotates strictly.
// Ports:
//   valid  in  N    request vector
//   last   in  IW   index granted most recently
//   winner out IW   first valid index after last (0 when none valid)
//   any    out 1    at least one valid bit set
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any
);

    logic [IW-1:0] idx;

    // Walk from the lowest priority (offset N, i.e. last itself) up to the
    // highest (offset 1) so the highest-priority hit is assigned last.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (valid[idx]) begin
                winner = idx;
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N_REQ byte sources using
// round-robin arbitration, and sequences the transmitter for each byte.
//
// Handshakes:
//   Requester side: a requester raises req_valid[i] with its byte on
//   req_data[i*DW +: DW], keeps both stable, and holds valid until it sees the
//   one-cycle req_ack[i] pulse; the byte is consumed on that ack cycle. A
//   requester may drop valid before ack and is then simply skipped.
//   Transmitter side: tx_rdy high means uart_tx is idle. The arbiter only
//   launches (one-cycle tx_en with tx_data) while idle with tx_rdy high, waits
//   for tx_rdy to fall (accept; or ARB_ACCEPT_TIMEOUT cycles still high), then
//   waits for tx_rdy to rise again before the next launch.
//
// Ports:
//   clk        in   1         system clock
//   rst        in   1         synchronous reset, active-high
//   req_valid  in   N_REQ     per-requester byte pending
//   req_data   in   N_REQ*DW  per-requester byte
//   req_lock   in   N_REQ     (UART_ARB_LOCK_EN only) keep grant on this requester
//   req_ack    out  N_REQ     one-cycle accept pulse, at most one bit high
//   tx_en      out  1         start pulse to uart_tx
//   tx_data    out  DW        byte to uart_tx (registered, held between launches)
//   tx_rdy     in   1         uart_tx idle
//   grant_id   out  IDW       last/current granted requester
//   busy       out  1         high from launch until uart_tx returns ready
//
// Optional feature macro: UART_ARB_LOCK_EN adds req_lock. When the lock bit of
// the granted requester is high on its launch cycle, the next arbitration
// gives that requester absolute priority if it is valid, keeping multi-byte
// messages contiguous.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int DW    = UART_DW,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]   req_lock,
`endif
    output logic [N_REQ-1:0]   req_ack,
    output logic               tx_en,
    output logic [DW-1:0]      tx_data,
    input  logic               tx_rdy,
    output logic [IDW-1:0]     grant_id,
    output logic               busy
);

    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);
    localparam logic [IDW-1:0]   GID_RESET = IDW'(N_REQ - 1);
    localparam logic [2:0]       ACC_LAST  = 3'(ARB_ACCEPT_TIMEOUT - 1);

    logic [1:0]     state;
    logic [2:0]     acc_cnt;
    logic [IDW-1:0] rr_winner;
    logic           rr_any;
    logic [IDW-1:0] pick;
    logic [DW-1:0]  data_arr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_arr[i] = req_data[i*DW +: DW];
        end
    end

    rr_pick #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .valid  (req_valid),
        .last   (grant_id),
        .winner (rr_winner),
        .any    (rr_any)
    );

`ifdef UART_ARB_LOCK_EN
    // Lock captured on the launch cycle of the current grant.
    logic lock_hold;

    always_comb begin
        pick = rr_winner;
        if (lock_hold && req_valid[grant_id]) begin
            pick = grant_id;
        end
    end
`else
    assign pick = rr_winner;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc_cnt  <= '0;
            tx_en    <= 1'b0;
            tx_data  <= '0;
            req_ack  <= '0;
            grant_id <= GID_RESET;
            busy     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_hold <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle by construction.
            tx_en   <= 1'b0;
            req_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (tx_rdy && rr_any) begin
                        tx_en    <= 1'b1;
                        tx_data  <= data_arr[pick];
                        req_ack  <= ONE_HOT0 << pick;
                        grant_id <= pick;
                        busy     <= 1'b1;
                        acc_cnt  <= '0;
                        state    <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
`ifdef UART_ARB_LOCK_EN
                    // tx_en high here marks the launch cycle.
                    if (tx_en) begin
                        lock_hold <= req_lock[grant_id];
                    end
`endif
                    // A transmitter that never drops rdy is assumed to have
                    // taken the byte anyway; no relaunch, no second ack.
                    if (!tx_rdy || acc_cnt == ACC_LAST) begin
                        state <= ST_WAIT_DONE;
                    end else begin
                        acc_cnt <= acc_cnt + 3'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_rdy) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ack;
  logic            tx_en;
  logic [DW-1:0]   tx_data;
  logic            tx_rdy = 1'b1;
  logic [IDW-1:0]  grant_id;
  logic            busy;
`ifdef UART_ARB_LOCK_EN
  logic [N-1:0]    req_lock = '0;
`endif

  uart_tx_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ack   (req_ack),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_rdy    (tx_rdy),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  // requester agents: pending bytes per source
  logic [DW-1:0] rq [N][$];
  // scoreboard: bytes the model says must be launched
  logic [DW-1:0] exp_q[$];
  // launch log observed from the DUT
  int            log_req[$];
  logic [DW-1:0] log_data[$];

  // uart_tx stand-in: 0 random, 1 fixed low time, 2 never drops rdy
  int uart_mode  = 1;
  int fixed_len  = 3;
  int start_in   = -1;
  int pend_len   = 0;
  int low_left   = 0;
  bit foreign_en = 1'b0;

  // behavioural model (transaction view: in flight / taken / age)
  logic          m_en = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0]  m_ack = '0;
  int            m_gid = N - 1;
  bit            m_busy = 1'b0;
  bit            m_taken = 1'b0;
  int            m_age = 0;
  bit            m_lockp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // first valid source after the previous grant, with lock override
  function automatic int model_pick();
    int w;
    w = -1;
`ifdef UART_ARB_LOCK_EN
    if (m_lockp && req_valid[m_gid]) return m_gid;
`endif
    for (int k = 1; k <= N; k++) begin
      if (w < 0 && req_valid[(m_gid + k) % N]) w = (m_gid + k) % N;
    end
    return w;
  endfunction

  task automatic model_step();
    int w;
    if (rst) begin
      m_en = 1'b0; m_data = '0; m_ack = '0; m_gid = N - 1;
      m_busy = 1'b0; m_taken = 1'b0; m_age = 0; m_lockp = 1'b0;
      return;
    end
    if (!m_busy) begin
      if (tx_rdy && req_valid != '0) begin
        w = model_pick();
        m_gid = w;
        m_data = req_data[w*DW +: DW];
        m_ack = '0;
        m_ack[w] = 1'b1;
        m_en = 1'b1;
        m_busy = 1'b1; m_taken = 1'b0; m_age = 0;
        exp_q.push_back(m_data);
        return;
      end
    end else if (!m_taken) begin
`ifdef UART_ARB_LOCK_EN
      if (m_en) m_lockp = req_lock[m_gid];
`endif
      m_age++;
      if (!tx_rdy || m_age == 4) m_taken = 1'b1;
    end else if (tx_rdy) begin
      m_busy = 1'b0;
    end
    m_en = 1'b0;
    m_ack = '0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rq[i].size() > 0);
      req_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : '0;
    end
  endtask

  // one clock: model predicts, DUT clocks, outputs compared, agents react
  task automatic cycle();
    logic [DW-1:0] b;
    drive_inputs();
    model_step();
    @(posedge clk);
    #1;
    chk("tx_en", tx_en, m_en);
    chk("tx_data", tx_data, m_data);
    chk("req_ack", req_ack, m_ack);
    chk("grant_id", grant_id, m_gid[IDW-1:0]);
    chk("busy", busy, m_busy);
    chk("ack_onehot", ($countones(req_ack) <= 1), 1);
    if (tx_en) begin
      for (int i = 0; i < N; i++) if (req_ack[i]) log_req.push_back(i);
      log_data.push_back(tx_data);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("launch_byte", tx_data, b);
      end else begin
        chk("unexpected_launch", tx_en, 0);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_ack[i] && rq[i].size() > 0) b = rq[i].pop_front();
    end
    if (tx_en) begin
      case (uart_mode)
        1: begin start_in = 0; pend_len = fixed_len; end
        2: ;
        default: begin
          if ($urandom_range(0, 9) != 0) begin
            start_in = $urandom_range(0, 5);
            pend_len = $urandom_range(1, 12);
          end
        end
      endcase
    end
    if (start_in == 0) begin
      low_left = pend_len;
      start_in = -1;
    end else if (start_in > 0) begin
      start_in--;
    end
    if (uart_mode == 0 && foreign_en && !busy && low_left == 0 && start_in < 0 &&
        $urandom_range(0, 19) == 0) begin
      low_left = $urandom_range(1, 5);
    end
    if (low_left > 0) begin
      tx_rdy = 1'b0;
      low_left--;
    end else begin
      tx_rdy = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  task automatic clear_env();
    for (int i = 0; i < N; i++) rq[i].delete();
    log_req.delete();
    log_data.delete();
  endtask

  task automatic wait_launches(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (log_req.size() < target && n < budget) begin
      cycle();
      n++;
    end
    chk(name, log_req.size(), target);
  endtask

  task automatic cycles_until_idle(output int n);
    n = 0;
    while (busy && n < 60) begin
      cycle();
      n++;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [DW-1:0] fair_exp [5];
    fair_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    // single requester
    clear_env();
    uart_mode = 1;
    fixed_len = 10;
    do_reset(2);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 3);
    chk("rst_tx_data", tx_data, 0);
    rq[0].push_back(8'h41);
    cycle();
    chk("single_tx_en", tx_en, 1);
    chk("single_tx_data", tx_data, 8'h41);
    chk("single_ack", req_ack, 4'b0001);
    chk("single_busy", busy, 1);
    cycles_until_idle(n);
    chk("single_busy_len", n, 11);

    // fairness: all valid, strict rotation
    clear_env();
    fixed_len = 3;
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      rq[i].push_back(8'(8'h10 + i));
      rq[i].push_back(8'(8'h10 + i));
    end
    wait_launches("fair_count", 5, 200);
    if (log_data.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("fair_order", log_data[k], fair_exp[k]);
    end

    // wrap: grant_id=3, sources 1 and 2 valid
    clear_env();
    do_reset(1);
    chk("wrap_gid", grant_id, 3);
    rq[1].push_back(8'h21);
    rq[2].push_back(8'h22);
    wait_launches("wrap_count", 2, 100);
    if (log_req.size() >= 2) begin
      chk("wrap_first", log_req[0], 1);
      chk("wrap_second", log_req[1], 2);
    end

    // transmitter never drops rdy: accept timeout
    clear_env();
    uart_mode = 2;
    rq[1].push_back(8'h31);
    wait_launches("timeout_launch", 1, 20);
    cycles_until_idle(n);
    chk("timeout_busy_len", n, 5);
    repeat (10) cycle();
    chk("timeout_single_launch", log_req.size(), 1);

    // reset in the third WAIT_DONE cycle
    clear_env();
    uart_mode = 1;
    fixed_len = 20;
    do_reset(1);
    rq[0].push_back(8'h51);
    rq[0].push_back(8'h52);
    rq[1].push_back(8'h61);
    wait_launches("midrst_launch", 1, 20);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_tx_en", tx_en, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_ack", req_ack, 0);
    chk("midrst_gid", grant_id, 3);
    chk("midrst_busy", busy, 0);
    wait_launches("midrst_next", 2, 100);
    if (log_req.size() >= 2) begin
      chk("midrst_next_req", log_req[1], 0);
      chk("midrst_next_data", log_data[1], 8'h52);
    end

`ifdef UART_ARB_LOCK_EN
    // locked multi-byte message stays contiguous
    clear_env();
    fixed_len = 3;
    do_reset(1);
    req_lock = 4'b0100;
    rq[2].push_back(8'hA0);
    rq[2].push_back(8'hA1);
    rq[2].push_back(8'hA2);
    wait_launches("lock_first", 1, 20);
    rq[0].push_back(8'hB0);
    rq[1].push_back(8'hC0);
    wait_launches("lock_count", 5, 200);
    if (log_data.size() >= 5) begin
      chk("lock_b1", log_data[1], 8'hA1);
      chk("lock_b2", log_data[2], 8'hA2);
      chk("lock_b3", log_data[3], 8'hB0);
      chk("lock_b4", log_data[4], 8'hC0);
    end
    req_lock = '0;
`endif

    // randomized traffic against the model
    clear_env();
    uart_mode = 0;
    foreign_en = 1'b1;
    do_reset(1);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() < 3 && $urandom_range(0, 7) == 0) rq[i].push_back(8'($urandom));
      end
      if (m_busy && $urandom_range(0, 49) == 0) begin
        n = $urandom_range(0, N - 1);
        if (rq[n].size() > 0) rq[n].delete(0);
      end
`ifdef UART_ARB_LOCK_EN
      if (c % 8 == 0) req_lock = 4'($urandom_range(0, 15));
`endif
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0;
    chk("random_traffic", (log_req.size() > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
